// File: rtl/miter_sweep_checker.sv
// miter_sweep_checker: sweeps every WIDTH-bit miter input vector (counter or
// Galois-LFSR order), aligns delayed miter triggers back to the vector that
// produced them, and accumulates error count, first failing vector and a
// per-channel failure mask.
module miter_sweep_checker #(
    parameter int                WIDTH       = 8,
    parameter int                CHANNELS    = 1,
    parameter int                LATENCY     = 0,
    parameter int                ERR_WIDTH   = 9,
    parameter int                MODE        = 0,
    parameter logic [WIDTH-1:0]  POLY        = WIDTH'(8'hB8),
    parameter int                STOP_ON_ERR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     in_A,
    input  logic [CHANNELS-1:0]  trigger,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_addr,
    output logic [CHANNELS-1:0]  err_chan_mask
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Drain counter starts at LATENCY-1 so DONE lands exactly LATENCY edges later.
    localparam logic [3:0] DRAIN_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      in_a_q, in_a_d;
    logic [3:0]            drain_q, drain_d;
    logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;
    logic                  first_err_valid_q, first_err_valid_d;
    logic [WIDTH-1:0]      first_err_addr_q, first_err_addr_d;
    logic [CHANNELS-1:0]   err_chan_mask_q, err_chan_mask_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  pipe_run;
    logic                  src_vld;
    logic                  chk_vld;
    logic [WIDTH-1:0]      chk_tag;
    logic                  chk_en;
    logic                  err_hit;
    logic                  is_last;
    logic [WIDTH-1:0]      next_vec;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY : '0);
    endfunction

    assign pipe_run = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign src_vld  = (state_q == S_RUN);

    // Tag pipeline: carries {valid, vector} alongside the miter's own latency.
    generate
        if (LATENCY == 0) begin : g_nopipe
            assign chk_vld = src_vld;
            assign chk_tag = in_a_q;
        end else begin : g_pipe
            for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
                logic             vld_q, vld_d;
                logic [WIDTH-1:0] tag_q, tag_d;
                logic             prev_vld;
                logic [WIDTH-1:0] prev_tag;

                if (gi == 0) begin : g_head
                    assign prev_vld = src_vld;
                    assign prev_tag = in_a_q;
                end else begin : g_link
                    assign prev_vld = g_stage[gi-1].vld_q;
                    assign prev_tag = g_stage[gi-1].tag_q;
                end

                // Shift one stage; outside RUN/DRAIN the pipe empties so stale tags never reach a new sweep.
                always_comb begin
                    vld_d = pipe_run && prev_vld;
                    tag_d = prev_tag;
                end

                // Stage register with synchronous clear.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        vld_q <= 1'b0;
                        tag_q <= '0;
                    end else begin
                        vld_q <= vld_d;
                        tag_q <= tag_d;
                    end
                end
            end
            assign chk_vld = g_stage[LATENCY-1].vld_q;
            assign chk_tag = g_stage[LATENCY-1].tag_q;
        end
    endgenerate

    assign chk_en  = chk_vld && pipe_run;
    assign err_hit = chk_en && (|trigger);

    // Sequence stepping: last-vector detection and successor for both orders.
    always_comb begin
        is_last  = 1'b0;
        next_vec = in_a_q;
        if (MODE == 0) begin
            is_last  = (in_a_q == '1);
            next_vec = in_a_q + WIDTH'(1);
        end else begin
            is_last  = (in_a_q != '0) && (lfsr_next(in_a_q) == WIDTH'(1));
            next_vec = (in_a_q == '0) ? WIDTH'(1) : lfsr_next(in_a_q);
        end
    end

    // Next-state logic: sweep control plus result accumulation.
    always_comb begin
        state_d           = state_q;
        in_a_d            = in_a_q;
        drain_d           = drain_q;
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_addr_d  = first_err_addr_q;
        err_chan_mask_d   = err_chan_mask_q;

        // Checks run in RUN and DRAIN; chk_en is already gated by that.
        if (chk_en) begin
            err_chan_mask_d = err_chan_mask_q | trigger;
            if (err_hit) begin
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + ERR_WIDTH'(1);
                end
                if (!first_err_valid_q) begin
                    first_err_valid_d = 1'b1;
                    first_err_addr_d  = chk_tag;
                end
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d           = S_RUN;
                    in_a_d            = '0;
                    drain_d           = '0;
                    err_count_d       = '0;
                    first_err_valid_d = 1'b0;
                    first_err_addr_d  = '0;
                    err_chan_mask_d   = '0;
                end
            end
            S_RUN: begin
                if ((STOP_ON_ERR != 0) && err_hit) begin
                    state_d = S_DONE;
                end else if (is_last) begin
                    if (LATENCY == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_INIT;
                    end
                end else begin
                    in_a_d = next_vec;
                end
            end
            S_DRAIN: begin
                if ((STOP_ON_ERR != 0) && err_hit) begin
                    state_d = S_DONE;
                end else if (drain_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            in_a_q            <= '0;
            drain_q           <= '0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_addr_q  <= '0;
            err_chan_mask_q   <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            in_a_q            <= in_a_d;
            drain_q           <= drain_d;
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_addr_q  <= first_err_addr_d;
            err_chan_mask_q   <= err_chan_mask_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
        end
    end

    assign in_A            = in_a_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = done_q && (err_count_q == '0);
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_addr  = first_err_addr_q;
    assign err_chan_mask   = err_chan_mask_q;

endmodule

// File: tb/tb_miter_sweep_checker.sv
// Testbench for miter_sweep_checker: a counter-order instance with a 3-cycle
// miter latency and two channels, and an LFSR-order stop-on-error instance.
module tb_miter_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: counter order, LATENCY 3, 2 channels, 4-bit error counter.
    logic       rst_n_a, start_a;
    logic [7:0] in_a_a;
    logic [1:0] trig_a;
    logic       busy_a, done_a, pass_a, fv_a;
    logic [3:0] err_a;
    logic [7:0] addr_a;
    logic [1:0] mask_a;

    miter_sweep_checker #(
        .WIDTH(8), .CHANNELS(2), .LATENCY(3), .ERR_WIDTH(4),
        .MODE(0), .POLY(8'hB8), .STOP_ON_ERR(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .in_A(in_a_a),
        .trigger(trig_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_valid(fv_a), .first_err_addr(addr_a),
        .err_chan_mask(mask_a)
    );

    // Instance B: LFSR order, combinational miter, stop on first error.
    logic       rst_n_b, start_b;
    logic [7:0] in_a_b;
    logic [0:0] trig_b;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [8:0] err_b;
    logic [7:0] addr_b;
    logic [0:0] mask_b;

    miter_sweep_checker #(
        .WIDTH(8), .CHANNELS(1), .LATENCY(0), .ERR_WIDTH(9),
        .MODE(1), .POLY(8'hB8), .STOP_ON_ERR(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .in_A(in_a_b),
        .trigger(trig_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_valid(fv_b), .first_err_addr(addr_b),
        .err_chan_mask(mask_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  seq[256];
    int          pos10;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
    endtask

    // Pop the oldest scoreboard entry and compare it against an observed value.
    task automatic chk_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    // Counter-order sweep on A. tmode 0: clean, 1: ch1 fails on vector 0x5A, 2: ch0 tied high.
    task automatic sweep_a(input int tmode);
        trig_a  = (tmode == 2) ? 2'b01 : 2'b00;
        start_a = 1'b1;
        exp_q.push_back(32'd0);
        tick();
        start_a = 1'b0;
        for (int cyc = 0; cyc <= 259; cyc++) begin
            chk_pop("a_in_A", {24'd0, in_a_a});
            if (busy_a !== (cyc < 259)) chk("a_busy", {31'd0, busy_a}, {31'd0, cyc < 259});
            if (done_a !== (cyc >= 259)) chk("a_done", {31'd0, done_a}, {31'd0, cyc >= 259});
            // Vector k's miter output appears 3 cycles after it and is sampled one edge later.
            if (tmode == 2)      trig_a = 2'b01;
            else if (tmode == 1) trig_a = (cyc == 32'h5A + 3) ? 2'b10 : 2'b00;
            else                 trig_a = 2'b00;
            if (cyc < 259) begin
                exp_q.push_back((cyc + 1 < 256) ? 32'(cyc + 1) : 32'd255);
                tick();
            end
        end
        chk("a_done_at_259", {31'd0, done_a}, 32'd1);
        chk("a_busy_off", {31'd0, busy_a}, 32'd0);
        case (tmode)
            1: begin
                chk("a_err_single", {28'd0, err_a}, 32'd1);
                chk("a_first_addr", {24'd0, addr_a}, 32'h5A);
                chk("a_first_valid", {31'd0, fv_a}, 32'd1);
                chk("a_mask", {30'd0, mask_a}, 32'b10);
                chk("a_pass", {31'd0, pass_a}, 32'd0);
            end
            2: begin
                chk("a_err_sat", {28'd0, err_a}, 32'd15);
                chk("a_first_addr0", {24'd0, addr_a}, 32'h00);
                chk("a_first_valid", {31'd0, fv_a}, 32'd1);
                chk("a_mask_sat", {30'd0, mask_a}, 32'b01);
                chk("a_pass_sat", {31'd0, pass_a}, 32'd0);
            end
            default: begin
                chk("a_err_clean", {28'd0, err_a}, 32'd0);
                chk("a_first_valid0", {31'd0, fv_a}, 32'd0);
                chk("a_mask_clean", {30'd0, mask_a}, 32'd0);
                chk("a_pass_clean", {31'd0, pass_a}, 32'd1);
            end
        endcase
        trig_a = 2'b00;
        tick();
        chk("a_in_A_hold", {24'd0, in_a_a}, 32'd255);
        chk("a_done_hold", {31'd0, done_a}, 32'd1);
    endtask

    initial begin
        logic [7:0] s;
        logic [255:0] seen;
        int uniq;

        seq[0] = 8'h00;
        s = 8'h01;
        for (int i = 1; i < 256; i++) begin
            seq[i] = s;
            s = lfsr_step(s);
        end
        pos10 = 0;
        for (int i = 0; i < 256; i++) if (seq[i] == 8'h10) pos10 = i;

        rst_n_a = 1'b0; start_a = 1'b0; trig_a = 2'b00;
        rst_n_b = 1'b0; start_b = 1'b0; trig_b = 1'b0;
        tick(); tick();
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        tick();

        // Reset state.
        chk("rst_in_A", {24'd0, in_a_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_pass", {31'd0, pass_a}, 32'd0);
        chk("rst_err", {28'd0, err_a}, 32'd0);
        chk("rst_fv", {31'd0, fv_a}, 32'd0);
        chk("rst_mask", {30'd0, mask_a}, 32'd0);
        chk("rst_b_busy", {31'd0, busy_b}, 32'd0);

        // Latency-aligned single channel error, then saturation after restart from DONE.
        sweep_a(1);
        sweep_a(2);

        // Mid-sweep reset at vector 0x80, with errors already accumulated.
        trig_a  = 2'b01;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int cyc = 1; cyc <= 8'h80; cyc++) tick();
        chk("mid_in_A", {24'd0, in_a_a}, 32'h80);
        chk("mid_err_nonzero", {31'd0, err_a != 4'd0}, 32'd1);
        rst_n_a = 1'b0;
        trig_a  = 2'b00;
        tick();
        rst_n_a = 1'b1;
        chk("mr_in_A", {24'd0, in_a_a}, 32'd0);
        chk("mr_busy", {31'd0, busy_a}, 32'd0);
        chk("mr_done", {31'd0, done_a}, 32'd0);
        chk("mr_pass", {31'd0, pass_a}, 32'd0);
        chk("mr_err", {28'd0, err_a}, 32'd0);
        chk("mr_fv", {31'd0, fv_a}, 32'd0);
        chk("mr_addr", {24'd0, addr_a}, 32'd0);
        chk("mr_mask", {30'd0, mask_a}, 32'd0);
        tick();
        chk("mr_idle_busy", {31'd0, busy_a}, 32'd0);
        sweep_a(0);

        // LFSR-order clean sweep on B.
        seen = '0;
        start_b = 1'b1;
        exp_q.push_back({24'd0, seq[0]});
        tick();
        start_b = 1'b0;
        for (int cyc = 0; cyc <= 256; cyc++) begin
            seen[in_a_b] = 1'b1;
            chk_pop("b_in_A", {24'd0, in_a_b});
            if (done_b !== (cyc >= 256)) chk("b_done", {31'd0, done_b}, {31'd0, cyc >= 256});
            if (cyc < 256) begin
                exp_q.push_back({24'd0, seq[(cyc + 1 < 256) ? cyc + 1 : 255]});
                tick();
            end
        end
        uniq = 0;
        for (int i = 0; i < 256; i++) if (seen[i]) uniq++;
        chk("b_unique", uniq, 32'd256);
        chk("b_done_at_256", {31'd0, done_b}, 32'd1);
        chk("b_pass", {31'd0, pass_b}, 32'd1);
        chk("b_err_clean", {23'd0, err_b}, 32'd0);

        // Stop on the first error, vector 0x10.
        start_b = 1'b1;
        exp_q.push_back(32'd0);
        tick();
        start_b = 1'b0;
        for (int cyc = 0; cyc <= pos10 + 3; cyc++) begin
            chk_pop("s_in_A", {24'd0, in_a_b});
            if (done_b !== (cyc >= pos10 + 1)) chk("s_done", {31'd0, done_b}, {31'd0, cyc >= pos10 + 1});
            trig_b = (seq[(cyc < pos10) ? cyc : pos10] == 8'h10) ? 1'b1 : 1'b0;
            if (cyc < pos10 + 3) begin
                exp_q.push_back({24'd0, seq[(cyc + 1 < pos10) ? cyc + 1 : pos10]});
                tick();
            end
        end
        chk("s_done_final", {31'd0, done_b}, 32'd1);
        chk("s_err_one", {23'd0, err_b}, 32'd1);
        chk("s_first_addr", {24'd0, addr_b}, 32'h10);
        chk("s_mask", {31'd0, mask_b}, 32'd1);
        chk("s_pass", {31'd0, pass_b}, 32'd0);
        chk("s_in_A_frozen", {24'd0, in_a_b}, 32'h10);
        trig_b = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
